// File: rtl/snn_control_sequencer_if.sv
// SNN control bus: sequencer (master) drives enables/select/status, stages (slave) report activity.
interface snn_control_sequencer_if #(
  parameter int TS_W = 2
);
  logic            start;
  logic            pause;
  logic            do_pool;
  logic            cap_active;
  logic            conv_ready;
  logic            pool_ready;
  logic            cap_enable;
  logic            conv_enable;
  logic            pool_enable;
  logic            stage_reset;
  logic            conv_or_pool;
  logic            busy;
  logic            done;
  logic            error;
  logic [TS_W-1:0] timestep;

  modport master (
    input  start, pause, do_pool, cap_active, conv_ready, pool_ready,
    output cap_enable, conv_enable, pool_enable, stage_reset, conv_or_pool,
           busy, done, error, timestep
  );

  modport slave (
    output start, pause, do_pool, cap_active, conv_ready, pool_ready,
    input  cap_enable, conv_enable, pool_enable, stage_reset, conv_or_pool,
           busy, done, error, timestep
  );
endinterface

// File: rtl/snn_control_sequencer.sv
// Runs NUM_TIMESTEPS capture->conv->(pool) passes per start; registered outputs, pause freezes everything.
// Optional per-phase watchdog under SNN_CTRL_TIMEOUT_EN; without it error is tied low.
module snn_control_sequencer #(
  parameter int NUM_TIMESTEPS  = 4,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  snn_control_sequencer_if.master  bus
);
  localparam int TS_W = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1;
  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_POOL = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_TOUT = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            seen_q, seen_d;
  logic            pool_q, pool_d;
  logic            cap_en_q, conv_en_q, pool_en_q, srst_q, cop_q, busy_q, done_q;

`ifdef SNN_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            in_phase, timeout;
`endif

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    ts_d    = ts_q;
    seen_d  = seen_q;
    pool_d  = pool_q;
`ifdef SNN_CTRL_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start && !bus.pause) begin
        state_d = S_CLR;
        rc_d    = '0;
        ts_d    = '0;
        pool_d  = bus.do_pool;
`ifdef SNN_CTRL_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      S_CLR: if (!bus.pause) begin
        if (rc_q == RC_W'(RESET_CYCLES - 1)) begin
          state_d = S_CAP;
          seen_d  = 1'b0;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      // Capture completes only on a high-then-low sequence of cap_active.
      S_CAP: if (!bus.pause) begin
        if (seen_q && !bus.cap_active) state_d = S_CONV;
        else if (bus.cap_active)       seen_d  = 1'b1;
      end
      S_CONV: if (!bus.pause && bus.conv_ready) state_d = pool_q ? S_POOL : S_NEXT;
      S_POOL: if (!bus.pause && bus.pool_ready) state_d = S_NEXT;
      S_NEXT: if (!bus.pause) begin
        if (ts_q == TS_W'(NUM_TIMESTEPS - 1)) begin
          state_d = S_DONE;
        end else begin
          ts_d    = ts_q + 1'b1;
          state_d = S_CAP;
          seen_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_TOUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SNN_CTRL_TIMEOUT_EN
    in_phase = (state_q == S_CAP) || (state_q == S_CONV) || (state_q == S_POOL);
    timeout  = in_phase && !bus.pause && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    if (timeout && (state_d == state_q)) begin
      state_d = S_TOUT;
      err_d   = 1'b1;
    end
    if (state_d != state_q)         wd_d = '0;
    else if (in_phase && !bus.pause) wd_d = wd_q + 1'b1;
    else                             wd_d = wd_q;
`endif
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rc_q      <= '0;
      ts_q      <= '0;
      seen_q    <= 1'b0;
      pool_q    <= 1'b0;
      cap_en_q  <= 1'b0;
      conv_en_q <= 1'b0;
      pool_en_q <= 1'b0;
      srst_q    <= 1'b0;
      cop_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      ts_q      <= ts_d;
      seen_q    <= seen_d;
      pool_q    <= pool_d;
      cap_en_q  <= (state_d == S_CAP)  && !bus.pause;
      conv_en_q <= (state_d == S_CONV) && !bus.pause;
      pool_en_q <= (state_d == S_POOL) && !bus.pause;
      srst_q    <= (state_d == S_CLR) || (state_d == S_TOUT);
      cop_q     <= (state_d != S_POOL);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

`ifdef SNN_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.cap_enable   = cap_en_q;
  assign bus.conv_enable  = conv_en_q;
  assign bus.pool_enable  = pool_en_q;
  assign bus.stage_reset  = srst_q;
  assign bus.conv_or_pool = cop_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timestep     = ts_q;
endmodule

// File: tb/tb_snn_control_sequencer.sv
// Directed bench for snn_control_sequencer: per-cycle output vectors against hand-derived expectations.
module tb_snn_control_sequencer;
  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  snn_control_sequencer_if #(.TS_W(2)) bus ();

  snn_control_sequencer #(
    .NUM_TIMESTEPS (4),
    .RESET_CYCLES  (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cap_en, conv_en, pool_en, stage_reset, conv_or_pool, busy, done, error}
  logic [7:0] outs;
  assign outs = {bus.cap_enable, bus.conv_enable, bus.pool_enable, bus.stage_reset,
                 bus.conv_or_pool, bus.busy, bus.done, bus.error};

  localparam logic [7:0] O_IDLE = 8'b0000_1000;
  localparam logic [7:0] O_CLR  = 8'b0001_1100;
  localparam logic [7:0] O_CAP  = 8'b1000_1100;
  localparam logic [7:0] O_CONV = 8'b0100_1100;
  localparam logic [7:0] O_POOL = 8'b0010_0100;
  localparam logic [7:0] O_HOLD = 8'b0000_1100;
  localparam logic [7:0] O_DONE = 8'b0000_1110;
`ifdef SNN_CTRL_TIMEOUT_EN
  localparam logic [7:0] O_TOUT = 8'b0001_1101;
  localparam logic [7:0] O_IERR = 8'b0000_1001;
`endif

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit pool);
    bus.do_pool = pool;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.do_pool = 1'b0;
    chk("clr0", outs, O_CLR);
    tick();
    chk("clr1", outs, O_CLR);
    tick();
    chk("cap_first", outs, O_CAP);
  endtask

  // Entered with the DUT freshly in CAPTURE for pass ts.
  task automatic do_pass(input int ts, input bit pool, input bit last);
    chk("ts", 8'(bus.timestep), 8'(ts));
    bus.cap_active = 1'b1;
    tick();
    chk("cap_seen", outs, O_CAP);
    bus.cap_active = 1'b0;
    tick();
    chk("conv_ent", outs, O_CONV);
    repeat (2) begin
      tick();
      chk("conv_wait", outs, O_CONV);
    end
    bus.conv_ready = 1'b1;
    tick();
    bus.conv_ready = 1'b0;
    if (pool) begin
      chk("pool_ent", outs, O_POOL);
      tick();
      chk("pool_wait", outs, O_POOL);
      bus.pool_ready = 1'b1;
      tick();
      bus.pool_ready = 1'b0;
    end
    chk("next", outs, O_HOLD);
    tick();
    if (last) begin
      chk("done", outs, O_DONE);
      tick();
      chk("idle_after", outs, O_IDLE);
      chk("ts_hold", 8'(bus.timestep), 8'(ts));
    end else begin
      chk("cap_ent", outs, O_CAP);
    end
  endtask

  initial begin
    reset_n        = 1'b1;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.do_pool    = 1'b0;
    bus.cap_active = 1'b0;
    bus.conv_ready = 1'b0;
    bus.pool_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_outs", outs, O_IDLE);
    chk("rst_ts", 8'(bus.timestep), 8'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle", outs, O_IDLE);

    // Four passes without pooling.
    start_run(1'b0);
    for (int i = 0; i < 4; i++) do_pass(i, 1'b0, i == 3);

    // Four passes with pooling.
    start_run(1'b1);
    for (int i = 0; i < 4; i++) do_pass(i, 1'b1, i == 3);

    // Pause in CONV with conv_ready asserted during the pause.
    start_run(1'b0);
    bus.cap_active = 1'b1;
    tick();
    bus.cap_active = 1'b0;
    tick();
    chk("p_conv", outs, O_CONV);
    bus.pause      = 1'b1;
    bus.conv_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("p_hold", outs, O_HOLD);
    end
    bus.pause      = 1'b0;
    bus.conv_ready = 1'b0;
    tick();
    chk("p_resume", outs, O_CONV);
    bus.conv_ready = 1'b1;
    tick();
    bus.conv_ready = 1'b0;
    chk("p_next", outs, O_HOLD);
    tick();
    chk("p_cap1", outs, O_CAP);
    chk("p_ts1", 8'(bus.timestep), 8'd1);

    // Start while busy is ignored; cap_active never high does not complete CAPTURE.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("s_ign", outs, O_CAP);
    repeat (3) begin
      tick();
      chk("cap_nohigh", outs, O_CAP);
    end
    chk("s_ts", 8'(bus.timestep), 8'd1);
    bus.cap_active = 1'b1;
    tick();
    bus.cap_active = 1'b0;
    tick();
    chk("s_conv", outs, O_CONV);
    bus.conv_ready = 1'b1;
    tick();
    bus.conv_ready = 1'b0;
    chk("s_next", outs, O_HOLD);
    tick();
    chk("s_cap2", outs, O_CAP);
    do_pass(2, 1'b0, 1'b0);
    do_pass(3, 1'b0, 1'b1);

    // Pause in CLR holds stage_reset, then reset mid-POOL of pass 1.
    bus.do_pool = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.do_pool = 1'b0;
    chk("c_clr0", outs, O_CLR);
    bus.pause = 1'b1;
    tick();
    chk("c_pclr", outs, O_CLR);
    tick();
    chk("c_pclr", outs, O_CLR);
    bus.pause = 1'b0;
    tick();
    chk("c_clr1", outs, O_CLR);
    tick();
    chk("c_cap", outs, O_CAP);
    do_pass(0, 1'b1, 1'b0);
    bus.cap_active = 1'b1;
    tick();
    bus.cap_active = 1'b0;
    tick();
    bus.conv_ready = 1'b1;
    tick();
    bus.conv_ready = 1'b0;
    chk("r_pool", outs, O_POOL);
    chk("r_ts", 8'(bus.timestep), 8'd1);
    reset_n = 1'b0;
    #1;
    chk("r_async", outs, O_IDLE);
    chk("r_ts0", 8'(bus.timestep), 8'd0);
    tick();
    chk("r_nodone", outs, O_IDLE);
    reset_n = 1'b1;
    tick();
    chk("r_idle", outs, O_IDLE);
    start_run(1'b0);
    for (int i = 0; i < 4; i++) do_pass(i, 1'b0, i == 3);

`ifdef SNN_CTRL_TIMEOUT_EN
    // Watchdog: conv_ready never arrives.
    start_run(1'b0);
    bus.cap_active = 1'b1;
    tick();
    bus.cap_active = 1'b0;
    tick();
    chk("t_conv", outs, O_CONV);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t_wait", outs, O_CONV);
    end
    tick();
    chk("t_tout", outs, O_TOUT);
    tick();
    chk("t_idle_err", outs, O_IERR);
    tick();
    chk("t_sticky", outs, O_IERR);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t_clr", outs, O_CLR);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/snn_control_sequencer.md
Name: snn_control_sequencer

Overview:
- Top-side master of the SNN control bus: drives enable, stage reset and conv/pool select; consumes active/ready from capture, convolution and pooling/arbiter stages.
- Runs NUM_TIMESTEPS passes of capture -> convolution -> optional pooling per start request, with pause support.
- Sits at the top level of the convolution subsystem and replaces ad-hoc testbench sequencing of enable/reset.

Parameters:
- NUM_TIMESTEPS, 4, passes per start request (>=1).
- RESET_CYCLES, 2, cycles stage_reset is held at run start (>=1).
- TIMEOUT_CYCLES, 1024, per-phase watchdog limit (used only with the optional feature).
- Localparam TS_W = max(1, $clog2(NUM_TIMESTEPS)).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled only in IDLE.
- pause  in  1  level; freezes the sequencer.
- do_pool  in  1  enables the pooling phase; sampled on the accepted start.
- cap_active  in  1  capture stage busy.
- conv_ready  in  1  convolution stage finished the current pass.
- pool_ready  in  1  pooling/arbiter stage finished the current pass.
- cap_enable  out  1  enable to capture stage.
- conv_enable  out  1  enable to convolution stage.
- pool_enable  out  1  enable to pooling stage.
- stage_reset  out  1  active-high synchronous reset to all stages.
- conv_or_pool  out  1  1 = conv, 0 = pool; arbiter select.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run completion.
- error  out  1  sticky watchdog flag.
- timestep  out  TS_W  index of the current pass.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, all outputs 0, conv_or_pool=1, counters 0, pool_q=0. Reset mid-run aborts immediately with no done pulse.
- All outputs are registered and decoded from the state register.
- IDLE: start=1 and pause=0 -> CLR. Latch pool_q=do_pool, clear error and timestep. start while busy is ignored.
- CLR: stage_reset=1 for exactly RESET_CYCLES cycles, then CAPTURE.
- CAPTURE: cap_enable=1. Phase completes after cap_active has been seen high (seen flag) and then sampled low -> CONV. cap_active already low with seen=0 does not complete the phase.
- CONV: conv_enable=1, conv_or_pool=1. conv_ready=1 -> POOL if pool_q, else NEXT.
- POOL: pool_enable=1, conv_or_pool=0. pool_ready=1 -> NEXT.
- NEXT (1 cycle, enables low):
  - timestep==NUM_TIMESTEPS-1 -> DONE.
  - Otherwise timestep+1 -> CAPTURE, with the seen flag cleared.
- DONE: done=1 for one cycle -> IDLE. timestep holds its last value until the next start.
- Latency with stages that respond immediately:
  - start -> first cap_enable = RESET_CYCLES+1 cycles.
  - One enable is asserted at a time, with no overlap.
- Pause: while pause=1, all enables are 0, and state, counters and seen flag are frozen. Completion inputs are ignored while paused. On release, the same phase resumes with its enable reasserted the next cycle. A pause during CLR holds stage_reset=1.
- Simultaneous events: conv_ready and pause in the same cycle -> pause wins and the phase does not complete. Ready inputs are level-sampled; a ready held high across phases does not skip the following phase, because each phase checks only its own input.
- A pass with NUM_TIMESTEPS=1 goes straight from NEXT to DONE.

Optional Feature:
- Macro SNN_CTRL_TIMEOUT_EN.
- With the macro:
  - A per-phase cycle counter runs in CAPTURE/CONV/POOL; it is cleared on phase entry and frozen during pause.
  - Reaching TIMEOUT_CYCLES -> error=1 (sticky until the next accepted start), enables low, one cycle of stage_reset=1, then IDLE with no done pulse.
- Without the macro: no counter is built, error is tied to 0, and phases wait indefinitely.

Test Plan:
- NUM_TIMESTEPS=4, do_pool=0, stages ack after 3 cycles -> four passes with timestep 0..3, no pool_enable ever, done pulses once, busy falls the same cycle done falls.
- do_pool=1 -> each pass shows cap_enable, then conv_enable with conv_or_pool=1, then pool_enable with conv_or_pool=0; stage_reset is high exactly 2 cycles after start.
- pause=1 for 5 cycles in CONV with conv_ready=1 asserted during the pause -> conv_enable=0, no advance; after release conv_enable returns and the phase completes.
- start pulsed during the run, and cap_active low without ever rising -> start ignored; CAPTURE does not complete until a high-then-low sequence is seen.
- reset_n low mid-POOL -> all outputs 0 asynchronously, no done; a new start runs normally from timestep 0.
- With SNN_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, conv_ready never asserted -> error=1 after 16 CONV cycles, one stage_reset pulse, IDLE; error cleared by the next start.
